// File: rtl/srl_32_core.sv
// 32-bit logical right shifter (MIPS SRL): log2 barrel shifter with a combinational
// result for single-cycle use and a registered result with a matching valid flag.
module srl_32_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] rt,
    input  logic [4:0]  shamt,
    output logic [31:0] rd,
    output logic        out_valid,
    output logic [31:0] rd_comb
);

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SHW   = 5;

    // stage[k] holds rt after the shifts selected by shamt[k-1:0]
    logic [WIDTH-1:0] stage [SHW+1];

    assign stage[0] = rt;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int unsigned DIST = 2 ** k;
        assign stage[k+1] = shamt[k] ? {{DIST{1'b0}}, stage[k][WIDTH-1:DIST]} : stage[k];
    end

    assign rd_comb = stage[SHW];

    // Result register holds across idle cycles so stray X on rt/shamt never lands in rd
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd        <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                rd <= rd_comb;
            end
        end
    end

endmodule

// File: tb/tb_srl_32_core.sv
// Self-checking bench for srl_32_core: directed plan steps plus random traffic
// against a plain-arithmetic reference (rt >> shamt) with a one-deep result register.
module tb_srl_32_core;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] rt;
    logic [4:0]  shamt;
    logic [31:0] rd;
    logic        out_valid;
    logic [31:0] rd_comb;

    int unsigned tests;
    int unsigned fails;

    logic [31:0] exp_rd;
    logic        exp_valid;

    srl_32_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .rt        (rt),
        .shamt     (shamt),
        .rd        (rd),
        .out_valid (out_valid),
        .rd_comb   (rd_comb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Drive one input at the falling edge, check the combinational result,
    // then step the reference register at the rising edge and check rd/out_valid.
    task automatic apply(input string tag, input logic v, input logic [31:0] r, input logic [4:0] s);
        logic [31:0] golden;
        @(negedge clk);
        in_valid = v;
        rt       = r;
        shamt    = s;
        golden   = r >> s;
        #1;
        if (v) check({tag, "/comb"}, rd_comb, golden);
        @(posedge clk);
        if (v) exp_rd = golden;
        exp_valid = v;
        #1;
        check({tag, "/rd"}, rd, exp_rd);
        check({tag, "/valid"}, 32'(out_valid), 32'(exp_valid));
    endtask

    // Values the plan lists explicitly for the sweep of 32'h805C9BD2
    function automatic logic [32:0] sweep_ref(input int s);
        case (s)
            0:       return {1'b1, 32'h805C9BD2};
            1:       return {1'b1, 32'h402E4DE9};
            3:       return {1'b1, 32'h100B937A};
            4:       return {1'b1, 32'h0805C9BD};
            8:       return {1'b1, 32'h00805C9B};
            16:      return {1'b1, 32'h0000805C};
            31:      return {1'b1, 32'h00000001};
            default: return 33'h0;
        endcase
    endfunction

    initial begin
        logic [32:0] ref_v;
        logic [31:0] iso [5];
        tests     = 0;
        fails     = 0;
        exp_rd    = '0;
        exp_valid = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        rt        = '0;
        shamt     = '0;

        // Reset state, including an input offered during reset being dropped
        #12;
        in_valid = 1'b1;
        rt       = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        check("reset/rd", rd, 32'h0);
        check("reset/valid", 32'(out_valid), 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // 1. Sweep
        for (int s = 0; s < 32; s++) begin
            apply($sformatf("sweep%0d", s), 1'b1, 32'h805C9BD2, 5'(s));
            ref_v = sweep_ref(s);
            if (ref_v[32]) check($sformatf("sweep%0d/table", s), rd, ref_v[31:0]);
        end

        // 2. MSB-set zero fill
        apply("ones4", 1'b1, 32'hFFFFFFFF, 5'd4);
        check("ones4/table", rd, 32'h0FFFFFFF);
        apply("ones31", 1'b1, 32'hFFFFFFFF, 5'd31);
        check("ones31/table", rd, 32'h00000001);

        // 3. Stage isolation
        iso[0] = 32'h40000000;
        iso[1] = 32'h20000000;
        iso[2] = 32'h08000000;
        iso[3] = 32'h00800000;
        iso[4] = 32'h00008000;
        for (int k = 0; k < 5; k++) begin
            apply($sformatf("iso%0d", k), 1'b1, 32'h80000000, 5'(1 << k));
            check($sformatf("iso%0d/table", k), rd, iso[k]);
        end

        // Zero operand across all shift amounts
        for (int s = 0; s < 32; s++) apply($sformatf("zero%0d", s), 1'b1, 32'h0, 5'(s));

        // 4. Valid / hold, including X on idle inputs
        apply("hold_load", 1'b1, 32'h12345678, 5'd4);
        check("hold_load/table", rd, 32'h01234567);
        apply("hold_idle", 1'b0, 32'hCAFEF00D, 5'd9);
        check("hold_idle/table", rd, 32'h01234567);
        apply("hold_x", 1'b0, 32'hxxxxxxxx, 5'bxxxxx);
        check("hold_x/table", rd, 32'h01234567);

        // 5. Async reset between edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset/rd", rd, 32'h0);
        check("areset/valid", 32'(out_valid), 32'h0);
        exp_rd    = '0;
        exp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_reset", 1'b1, 32'h805C9BD2, 5'd0);
        check("post_reset/table", rd, 32'h805C9BD2);

        // 6. Random back-to-back traffic
        for (int i = 0; i < 1000; i++) begin
            apply("rand", 1'b1, 32'($urandom), 5'($urandom_range(0, 31)));
        end
        apply("rand_idle", 1'b0, 32'($urandom), 5'($urandom_range(0, 31)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
